// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch initiator.
//
// Owns the program counter, issues one instruction-ROM read per cycle whenever
// the 2-entry queue has room (or is draining this cycle), captures the ROM's
// combinational read data into the queue, and presents the queue head to
// decode through a valid/ready handshake. A branch redirect flushes the queue
// and restarts fetch at the word-aligned target.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   rom_ce         out  1   ROM read issued this cycle
//   rom_addr       out  32  ROM byte address (always the current pc)
//   rom_inst       in   32  ROM read data, combinational from rom_addr
//   branch_flag    in   1   redirect: flush queue, restart at branch_target
//   branch_target  in   32  redirect address, bits [1:0] ignored
//   id_valid       out  1   queue head valid for decode
//   id_ready       in   1   decode accepts the head this cycle
//   id_pc          out  32  pc of the queue head (0 when empty)
//   id_inst        out  32  instruction of the queue head (0 when empty)

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    logic                   en_q,     en_d;
    logic [InstAddrBus-1:0] pc_q,     pc_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q,  count_d;
    logic [InstAddrBus-1:0] fifo_pc_q   [2];
    logic [InstAddrBus-1:0] fifo_pc_d   [2];
    logic [InstBus-1:0]     fifo_inst_q [2];
    logic [InstBus-1:0]     fifo_inst_d [2];

    logic head_valid;
    logic push;
    logic pop;

    // Target byte offset is discarded; fetch is always word aligned.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^branch_target[1:0];

    // Handshake and fetch issue. Only branch_flag and id_ready reach rom_ce and
    // id_valid combinationally; rom_inst only feeds queue storage.
    always_comb begin
        head_valid = (count_q != 2'd0);
        id_valid   = head_valid & ~branch_flag;
        pop        = id_valid & id_ready;
        // Issue when there is room, or when the full queue drains this cycle.
        push       = en_q & ~branch_flag & ((count_q < 2'd2) | pop);
        rom_ce     = push;
        rom_addr   = pc_q;
        id_pc      = head_valid ? fifo_pc_q[rd_ptr_q]   : '0;
        id_inst    = head_valid ? fifo_inst_q[rd_ptr_q] : '0;
    end

    always_comb begin
        en_d        = 1'b1;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;

        if (branch_flag) begin
            // Flush; push and pop are already suppressed by branch_flag.
            pc_d     = {branch_target[31:2], 2'b00};
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = pc_q;
                fifo_inst_d[wr_ptr_q] = rom_inst;
                wr_ptr_d              = ~wr_ptr_q;
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            pc_q        <= RESET_PC;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            fifo_pc_q   <= '{default: '0};
            fifo_inst_q <= '{default: '0};
        end else begin
            en_q        <= en_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_inst      (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word i holds 32'h3400_0000 + i.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h3400_0000 + {2'b00, a[31:2]};
    endfunction

    assign rom_inst = rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch enable, pc and a queue of in-flight entries.
    bit          m_en = 0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    initial forever begin
        bit pop_now;
        bit fetch_now;
        @(posedge clk);
        if (rst) begin
            m_en = 0;
            m_pc = RESET_PC;
            q_pc.delete();
            q_inst.delete();
        end else if (branch_flag) begin
            m_en = 1;
            m_pc = branch_target & 32'hFFFF_FFFC;
            q_pc.delete();
            q_inst.delete();
        end else begin
            pop_now   = (q_pc.size() != 0) && id_ready;
            fetch_now = m_en && ((q_pc.size() < 2) || pop_now);
            if (pop_now) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (fetch_now) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(rom_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
            m_en = 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        bit          e_valid;
        bit          e_ce;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        @(negedge clk);
        if (chk_en) begin
            e_valid = (q_pc.size() != 0) && !branch_flag;
            e_ce    = m_en && !branch_flag && ((q_pc.size() < 2) || (e_valid && id_ready));
            e_pc    = (q_pc.size() != 0) ? q_pc[0]   : 32'h0;
            e_inst  = (q_pc.size() != 0) ? q_inst[0] : 32'h0;
            check("model_rom_ce",   {31'b0, rom_ce},   {31'b0, e_ce});
            check("model_rom_addr", rom_addr,          m_pc);
            check("model_id_valid", {31'b0, id_valid}, {31'b0, e_valid});
            check("model_id_pc",    id_pc,             e_pc);
            check("model_id_inst",  id_inst,           e_inst);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"},    {31'b0, rom_ce},   32'h0);
        check({tag, "_addr"},  rom_addr,          RESET_PC);
        check({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
        check({tag, "_pc"},    id_pc,             32'h0);
        check({tag, "_inst"},  id_inst,           32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b1;
        step();
        step();

        // Reset release: cycle R
        chk_en = 1;
        rst    = 1'b0;
        neg();
        check_reset_outputs("rst_R");

        // R+1: first fetch issued
        step(); neg();
        check("R1_ce",    {31'b0, rom_ce},   32'h1);
        check("R1_addr",  rom_addr,          32'h0);
        check("R1_valid", {31'b0, id_valid}, 32'h0);

        // R+2: first valid; backpressure starts now for 5 cycles
        step(); id_ready = 1'b0; neg();
        check("R2_valid", {31'b0, id_valid}, 32'h1);
        check("R2_pc",    id_pc,             32'h0);
        check("R2_inst",  id_inst,           32'h3400_0000);
        check("R2_ce",    {31'b0, rom_ce},   32'h1);
        check("R2_addr",  rom_addr,          32'h4);

        step(); neg();
        check("bp_full_ce",   {31'b0, rom_ce}, 32'h0);
        check("bp_full_addr", rom_addr,        32'h8);

        step(); step(); step(); neg();
        check("bp_hold_ce",   {31'b0, rom_ce}, 32'h0);
        check("bp_hold_addr", rom_addr,        32'h8);
        check("bp_hold_pc",   id_pc,           32'h0);

        // Release: push and pop together at full
        step(); id_ready = 1'b1; neg();
        check("pp_full_ce", {31'b0, rom_ce}, 32'h1);
        check("order0_pc",  id_pc,           32'h0);
        step(); neg();
        check("order1_pc",  id_pc,           32'h4);
        check("pp_full_ce2", {31'b0, rom_ce}, 32'h1);
        step(); neg();
        check("order2_pc",   id_pc,   32'h8);
        check("order2_inst", id_inst, 32'h3400_0002);

        // Redirect with the queue full
        step(); id_ready = 1'b0; neg();
        step(); branch_flag = 1'b1; branch_target = 32'h0000_0043; neg();
        check("br_valid", {31'b0, id_valid}, 32'h0);
        check("br_ce",    {31'b0, rom_ce},   32'h0);
        step(); branch_flag = 1'b0; id_ready = 1'b1; neg();
        check("br1_addr",  rom_addr,          32'h40);
        check("br1_valid", {31'b0, id_valid}, 32'h0);
        step(); neg();
        check("br2_valid", {31'b0, id_valid}, 32'h1);
        check("br2_pc",    id_pc,             32'h40);
        check("br2_inst",  id_inst,           32'h3400_0010);
        step(); neg();
        check("br3_pc", id_pc, 32'h44);

        // Wrap-around of the program counter
        step(); branch_flag = 1'b1; branch_target = 32'hFFFF_FFF8; neg();
        step(); branch_flag = 1'b0; neg();
        check("wrap_a0", rom_addr, 32'hFFFF_FFF8);
        step(); neg();
        check("wrap_a1",    rom_addr, 32'hFFFF_FFFC);
        check("wrap_pc0",   id_pc,    32'hFFFF_FFF8);
        check("wrap_inst0", id_inst,  32'h73FF_FFFE);
        step(); neg();
        check("wrap_a2",  rom_addr, 32'h0000_0000);
        check("wrap_pc1", id_pc,    32'hFFFF_FFFC);
        step(); neg();
        check("wrap_a3",  rom_addr, 32'h0000_0004);
        check("wrap_pc2", id_pc,    32'h0000_0000);

        // Fill the queue, then reset together with a redirect
        step(); id_ready = 1'b0;
        step(); neg();
        check("fill_ce", {31'b0, rom_ce}, 32'h0);
        step(); rst = 1'b1; branch_flag = 1'b1; branch_target = 32'h0000_0100; neg();
        step(); rst = 1'b0; branch_flag = 1'b0; id_ready = 1'b1; neg();
        check_reset_outputs("mrst_R");
        step(); neg();
        check("mrst1_ce",   {31'b0, rom_ce}, 32'h1);
        check("mrst1_addr", rom_addr,        RESET_PC);

        // Stream at one instruction per cycle
        for (int k = 0; k < 4; k++) begin
            step(); neg();
            check("stream_valid", {31'b0, id_valid}, 32'h1);
            check("stream_pc",    id_pc,             32'(4 * k));
            check("stream_inst",  id_inst,           32'h3400_0000 + 32'(k));
        end

        step(); step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
